// File: rtl/rv_dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: load/store function codes,
// FSM state encoding and the access-size decode used for lane generation.
package rv_dmem_bridge_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_DONE
  } dm_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } dm_size_e;

  // Unsigned variants make no sense for stores, so they fall back to a word access.
  function automatic dm_size_e ldst_size(input logic [2:0] fun, input logic we);
    dm_size_e sz;
    sz = SZ_WORD;
    case (fun)
      LDST_B:  sz = SZ_BYTE;
      LDST_H:  sz = SZ_HALF;
      LDST_BU: sz = we ? SZ_WORD : SZ_BYTE;
      LDST_HU: sz = we ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/rv_dmem_lane_gen.sv
// Combinational byte-enable, store-data replication and misalignment detection
// for one load/store request.
module rv_dmem_lane_gen
  import rv_dmem_bridge_pkg::*;
(
  input  logic [2:0]  fun,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misaligned
);

  dm_size_e size;

  assign size = ldst_size(fun, we);

  always_comb begin
    sel        = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: sel = 4'b0001 << addr_lo;
      SZ_HALF: begin
        sel        = 4'b0011 << {addr_lo[1], 1'b0};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  // Replicate the right-aligned store data across every lane so the slave
  // can pick it up from whichever lane sel enables.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata[gi*8 +: 8] = (size == SZ_BYTE) ? data[7:0] :
                                (size == SZ_HALF) ? data[(gi%2)*8 +: 8] :
                                                    data[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/rv_dmem_bridge.sv
// Load/store request side: turns execute strobes into one pipelined bus
// transaction and returns the raw load word with one-cycle completion pulses.
module rv_dmem_bridge
  import rv_dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned TIMEOUT_WIDTH = 8,
  parameter logic [31:0] ERR_DATA      = ERR_DATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_dm_data_s_i,
  output logic        dm_busy_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  output logic        bus_we_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  input  logic        bus_stall_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_dat_i
);

  dm_state_e                state_reg;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_reg;
  logic                     we_reg;
  logic                     cyc_reg;
  logic                     stb_reg;
  logic [31:0]              adr_reg;
  logic [31:0]              dat_reg;
  logic [3:0]               sel_reg;
  logic [31:0]              data_l_reg;
  logic                     load_done_reg;
  logic                     store_done_reg;
  logic                     error_reg;

  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        req_misaligned;
  logic        tmo_hit;
  logic        fin;
  logic        fin_err;
  logic        fin_we;

  assign req_valid = x_load_i | x_store_i;
  assign req_we    = x_store_i & ~x_load_i;

  rv_dmem_lane_gen u_lane_gen (
    .fun        (x_fun_i),
    .we         (req_we),
    .addr_lo    (x_dm_addr_i[1:0]),
    .data       (x_dm_data_s_i),
    .sel        (req_sel),
    .wdata      (req_wdata),
    .misaligned (req_misaligned)
  );

  generate
    if (TIMEOUT == 0) begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end else begin : g_tmo
      assign tmo_hit = (tmo_cnt_reg == TIMEOUT_WIDTH'(TIMEOUT - 1));
    end
  endgenerate

  // Decide whether the transaction finishes at this edge and whether it failed.
  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_misaligned) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_STROBE: begin
        if (!bus_stall_i && (bus_ack_i || bus_err_i)) begin
          fin     = 1'b1;
          fin_err = bus_err_i;
        end
      end
      ST_WAIT_ACK: begin
        if (bus_ack_i || bus_err_i || tmo_hit) begin
          fin     = 1'b1;
          fin_err = bus_err_i | ~bus_ack_i;
        end
      end
      default: ;
    endcase
  end

  assign fin_we = (state_reg == ST_IDLE) ? req_we : we_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_IDLE;
      tmo_cnt_reg    <= '0;
      we_reg         <= 1'b0;
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      sel_reg        <= '0;
      data_l_reg     <= '0;
      load_done_reg  <= 1'b0;
      store_done_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      load_done_reg  <= fin & ~fin_we;
      store_done_reg <= fin & fin_we;
      error_reg      <= fin & fin_err;
      if (fin && !fin_we) begin
        data_l_reg <= fin_err ? ERR_DATA : bus_dat_i;
      end

      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg <= req_we;
            if (!req_misaligned) begin
              state_reg <= ST_STROBE;
              cyc_reg   <= 1'b1;
              stb_reg   <= 1'b1;
              adr_reg   <= {x_dm_addr_i[31:2], 2'b00};
              sel_reg   <= req_sel;
              dat_reg   <= req_wdata;
            end
          end
        end
        ST_STROBE: begin
          if (!bus_stall_i) begin
            stb_reg     <= 1'b0;
            tmo_cnt_reg <= '0;
            state_reg   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      if (fin) begin
        state_reg <= ST_DONE;
        cyc_reg   <= 1'b0;
        stb_reg   <= 1'b0;
      end
    end
  end

  assign dm_busy_o       = (state_reg != ST_IDLE);
  assign dm_data_l_o     = data_l_reg;
  assign dm_load_done_o  = load_done_reg;
  assign dm_store_done_o = store_done_reg;
  assign dm_error_o      = error_reg;
  assign bus_adr_o       = adr_reg;
  assign bus_dat_o       = dat_reg;
  assign bus_sel_o       = sel_reg;
  assign bus_we_o        = we_reg;
  assign bus_cyc_o       = cyc_reg;
  assign bus_stb_o       = stb_reg;

endmodule

// File: tb/tb_rv_dmem_bridge.sv
// Randomized self-checking bench for rv_dmem_bridge with a transaction-level
// reference model that predicts bus fields, completion cycle and load data.
module tb_rv_dmem_bridge;
  import rv_dmem_bridge_pkg::*;

  localparam int          TMO  = 4;
  localparam logic [31:0] EDAT = 32'hDEADBEEF;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        x_load_i = 1'b0;
  logic        x_store_i = 1'b0;
  logic [2:0]  x_fun_i = '0;
  logic [31:0] x_dm_addr_i = '0;
  logic [31:0] x_dm_data_s_i = '0;
  logic        dm_busy_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_error_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic        bus_we_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_stall_i = 1'b0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;
  logic [31:0] bus_dat_i = '0;

  always #5 clk_i = ~clk_i;

  rv_dmem_bridge #(
    .TIMEOUT       (TMO),
    .TIMEOUT_WIDTH (8),
    .ERR_DATA      (EDAT)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .x_load_i        (x_load_i),
    .x_store_i       (x_store_i),
    .x_fun_i         (x_fun_i),
    .x_dm_addr_i     (x_dm_addr_i),
    .x_dm_data_s_i   (x_dm_data_s_i),
    .dm_busy_o       (dm_busy_o),
    .dm_data_l_o     (dm_data_l_o),
    .dm_load_done_o  (dm_load_done_o),
    .dm_store_done_o (dm_store_done_o),
    .dm_error_o      (dm_error_o),
    .bus_adr_o       (bus_adr_o),
    .bus_dat_o       (bus_dat_o),
    .bus_sel_o       (bus_sel_o),
    .bus_we_o        (bus_we_o),
    .bus_cyc_o       (bus_cyc_o),
    .bus_stb_o       (bus_stb_o),
    .bus_stall_i     (bus_stall_i),
    .bus_ack_i       (bus_ack_i),
    .bus_err_i       (bus_err_i),
    .bus_dat_i       (bus_dat_i)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_txn = 0;
  logic [31:0] last_load = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // resp: 0 ack, 1 err, 2 ack+err, 3 silent slave. lat counts from the accept cycle.
  task automatic do_txn(input bit ld, input bit st, input logic [2:0] fun,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int stall_n, input int lat, input int resp,
                        input logic [31:0] rd);
    bit          we, mis, err, hit;
    int          size, sh, a, d;
    logic [3:0]  esel;
    logic [31:0] edat, eadr, exp_l;

    we = st && !ld;
    if (fun == LDST_B || (!we && fun == LDST_BU))      size = 1;
    else if (fun == LDST_H || (!we && fun == LDST_HU)) size = 2;
    else                                               size = 4;
    sh   = (size == 1) ? int'(addr[1:0]) : (size == 2) ? int'(addr[1:0] & 2'b10) : 0;
    esel = 4'(((1 << size) - 1) << sh);
    edat = (size == 1) ? 32'(wd[7:0]) * 32'h01010101 :
           (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
    eadr = addr & 32'hFFFF_FFFC;
    mis  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);

    a = 1 + stall_n;
    if (mis) begin
      d = 1; err = 1'b1;
    end else if (resp != 3 && lat <= TMO) begin
      d = a + lat + 1; err = (resp != 0);
    end else begin
      d = a + TMO + 1; err = 1'b1;
    end
    exp_l = we ? last_load : (err ? EDAT : rd);

    for (int k = 0; k <= d; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        chk("idle_busy", 32'(dm_busy_o), 32'd0);
        chk("idle_cyc", 32'(bus_cyc_o), 32'd0);
      end else begin
        chk("stb", 32'(bus_stb_o), 32'(!mis && k <= a));
        chk("cyc", 32'(bus_cyc_o), 32'(!mis && k < d));
        chk("busy", 32'(dm_busy_o), 32'd1);
        chk("load_done", 32'(dm_load_done_o), 32'(k == d && !we));
        chk("store_done", 32'(dm_store_done_o), 32'(k == d && we));
        chk("error", 32'(dm_error_o), 32'(k == d && err));
        if (!mis && k <= a) begin
          chk("adr", bus_adr_o, eadr);
          chk("sel", 32'(bus_sel_o), 32'(esel));
          chk("we", 32'(bus_we_o), 32'(we));
          if (we) chk("dat", bus_dat_o, edat);
        end
        if (k == d) chk("data_l", dm_data_l_o, exp_l);
      end

      if (k == 0) begin
        x_load_i = ld; x_store_i = st; x_fun_i = fun;
        x_dm_addr_i = addr; x_dm_data_s_i = wd;
      end else begin
        x_load_i      = ($urandom_range(3) == 0);
        x_store_i     = ($urandom_range(3) == 0);
        x_fun_i       = 3'($urandom);
        x_dm_addr_i   = $urandom;
        x_dm_data_s_i = $urandom;
      end
      if (!mis && k >= 1 && k < a)       bus_stall_i = 1'b1;
      else if (!mis && k == a)           bus_stall_i = 1'b0;
      else                               bus_stall_i = 1'($urandom);
      hit = !mis && resp != 3 && k == a + lat && k < d;
      if (hit) begin
        bus_ack_i = (resp != 1); bus_err_i = (resp != 0); bus_dat_i = rd;
      end else if (k == 0 || k == d) begin
        bus_ack_i = 1'($urandom); bus_err_i = 1'($urandom); bus_dat_i = $urandom;
      end else begin
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_dat_i = $urandom;
      end
    end
    x_load_i = 1'b0; x_store_i = 1'b0;
    if (!we) last_load = exp_l;
    n_txn++;
    $display("txn %0d: %s fun=%0d addr=%08h stall=%0d lat=%0d resp=%0d done@+%0d err=%0b",
             n_txn, we ? "store" : "load", fun, addr, stall_n, lat, resp, d, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus_stb_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_busy", 32'(dm_busy_o), 32'd0);
    chk("rst_done", 32'({dm_load_done_o, dm_store_done_o, dm_error_o}), 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_adr", bus_adr_o, 32'd0);
    chk("rst_dat", bus_dat_o, 32'd0);
    chk("rst_data_l", dm_data_l_o, 32'd0);
    rst_n_i = 1'b1;

    do_txn(1, 0, LDST_L, 32'h100, 32'h0, 0, 1, 0, 32'h11223344);
    do_txn(0, 1, LDST_B, 32'h203, 32'hAB, 3, 1, 0, 32'h0);
    do_txn(1, 0, LDST_H, 32'h101, 32'h0, 0, 0, 0, 32'h0);
    do_txn(1, 0, LDST_L, 32'h104, 32'h0, 0, 0, 3, 32'h0);
    do_txn(1, 0, LDST_L, 32'h108, 32'h0, 1, 2, 0, 32'hCAFEF00D);
    do_txn(1, 0, LDST_L, 32'h10C, 32'h0, 0, 2, 2, 32'h55555555);
    do_txn(0, 1, LDST_H, 32'h206, 32'h1234, 0, 0, 0, 32'h0);
    do_txn(1, 1, LDST_HU, 32'h30A, 32'h0, 1, 0, 1, 32'h0);
    do_txn(0, 1, LDST_BU, 32'h401, 32'h0, 0, 0, 0, 32'h0);

    // Reset while waiting for the acknowledge: no completion, late ack ignored.
    @(negedge clk_i);
    chk("rw_idle", 32'(dm_busy_o), 32'd0);
    x_load_i = 1'b1; x_fun_i = LDST_L; x_dm_addr_i = 32'h300;
    bus_stall_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk_i);
    chk("rw_stb", 32'(bus_stb_o), 32'd1);
    x_load_i = 1'b0;
    @(negedge clk_i);
    chk("rw_wait_cyc", 32'(bus_cyc_o), 32'd1);
    chk("rw_wait_stb", 32'(bus_stb_o), 32'd0);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("rw_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rw_stb0", 32'(bus_stb_o), 32'd0);
    chk("rw_busy", 32'(dm_busy_o), 32'd0);
    chk("rw_done", 32'({dm_load_done_o, dm_error_o}), 32'd0);
    rst_n_i = 1'b1; bus_ack_i = 1'b1; bus_dat_i = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("late_ack_done", 32'({dm_load_done_o, dm_store_done_o}), 32'd0);
      chk("late_ack_busy", 32'(dm_busy_o), 32'd0);
      bus_ack_i = 1'b0;
    end
    last_load = '0;
    $display("txn reset-in-wait_ack applied");

    for (int t = 0; t < 250; t++) begin
      bit ld, st;
      int r, resp;
      r  = $urandom_range(9);
      ld = (r < 5) || (r == 9);
      st = (r >= 5);
      r  = $urandom_range(9);
      resp = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      do_txn(ld, st, 3'($urandom), $urandom, $urandom,
             $urandom_range(3), $urandom_range(TMO + 1), resp, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
